// File: rtl/mix_columns_iter.sv
// Iterative AES (Inv)MixColumns engine: latches one 128-bit state and transforms
// COLS_PER_CYCLE columns per clock, then holds the result until the sink takes it.
//
// state | meaning
// IDLE  | waiting for a block, in_ready high
// BUSY  | rewriting the work register column by column
// DONE  | result held on out_data, out_valid high
module mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [1:0]   mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [2:0]   col_q, col_d;
  logic [1:0]   mode_q, mode_d;
  logic [127:0] work_q, work_d;
  logic [3:0]   col_end;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] xform(input logic [31:0] c, input logic [1:0] m);
    logic [7:0]  a  [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [7:0]  r  [4];
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2[i] = xt(a[i]);
      x4[i] = xt(x2[i]);
      x8[i] = xt(x4[i]);
    end
    // inverse coefficients: 0e = 8^4^2, 0b = 8^2^1, 0d = 8^4^1, 09 = 8^1
    for (int i = 0; i < 4; i++) begin
      if (m == 2'b00)
        r[i] = x2[i] ^ x2[(i+1)%4] ^ a[(i+1)%4] ^ a[(i+2)%4] ^ a[(i+3)%4];
      else if (m == 2'b01)
        r[i] = (x8[i] ^ x4[i] ^ x2[i])
             ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ a[(i+1)%4])
             ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ a[(i+2)%4])
             ^ (x8[(i+3)%4] ^ a[(i+3)%4]);
      else
        r[i] = a[i];
    end
    res = {r[0], r[1], r[2], r[3]};
    return res;
  endfunction

  assign col_end = {1'b0, col_q} + 4'(COLS_PER_CYCLE);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    mode_d  = mode_q;
    work_d  = work_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          mode_d  = mode;
          col_d   = 3'd0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        for (int j = 0; j < 4; j++) begin
          if (4'(j) >= {1'b0, col_q} && 4'(j) < col_end)
            work_d[127-32*j -: 32] = xform(work_q[127-32*j -: 32], mode_q);
        end
        col_d = col_end[2:0];
        if (col_end >= 4'd4) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      col_q   <= 3'd0;
      mode_q  <= 2'b00;
      work_q  <= 128'd0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      mode_q  <= mode_d;
      work_q  <= work_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) && rst_n;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = work_q;

endmodule
